// File: rtl/sipo_dbuf_if.sv
// Handshake bundle for sipo_dbuf. The serial side is s_*, the parallel frame side is p_*.
// master = upstream/downstream environment, slave = the converter.
interface sipo_dbuf_if #(
    parameter int W  = 32,
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
);
    logic [W-1:0]   s_in;
    logic           s_valid;
    logic           s_last;
    logic           s_ready;
    logic [N*W-1:0] p_out;
    logic [CW-1:0]  p_count;
    logic           p_valid;
    logic           p_ready;

    modport master (
        output s_in, s_valid, s_last, p_ready,
        input  s_ready, p_out, p_count, p_valid
    );

    modport slave (
        input  s_in, s_valid, s_last, p_ready,
        output s_ready, p_out, p_count, p_valid
    );
endinterface

// File: rtl/sipo_dbuf.sv
// Serial-in / parallel-out converter with one frame of buffering behind the output register.
// Completed frames go straight to the output when it is free, otherwise they park in the fill buffer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | collecting words into the fill buffer, s_ready high
// ST_HELD | fill buffer holds a complete frame waiting for the output
module sipo_dbuf #(
    parameter int W  = 32,
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    sipo_dbuf_if.slave    bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [IW-1:0]  r_idx;
    logic [N*W-1:0] r_fill;
    logic [CW-1:0]  r_hold_cnt;
    logic [N*W-1:0] r_p_out;
    logic [CW-1:0]  r_p_count;
    logic           r_p_valid;

    logic [N*W-1:0] w_frame;
    logic [CW-1:0]  w_cnt;
    logic           w_s_ready;
    logic           w_accept;
    logic           w_free;
    logic           w_complete;
    logic           w_load_direct;
    logic           w_load_held;
    logic           w_store;

    assign w_s_ready  = (r_state == ST_FILL) && !rst;
    assign w_accept   = bus.s_valid && w_s_ready;
    assign w_free     = !r_p_valid || bus.p_ready;
    assign w_complete = w_accept && ((r_idx == IW'(N - 1)) || bus.s_last);
    assign w_cnt      = CW'(r_idx) + CW'(1);

    // Lanes at and above idx are always zero in the fill buffer, so merging the
    // current word gives the finished frame with its unused lanes already cleared.
    always_comb begin
        w_frame = r_fill;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) begin
                w_frame[i*W +: W] = bus.s_in;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_direct = 1'b0;
        w_load_held   = 1'b0;
        w_store       = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_complete) begin
                    if (w_free) begin
                        w_load_direct = 1'b1;
                    end else begin
                        w_store     = 1'b1;
                        w_state_nxt = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (w_free) begin
                    w_load_held = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= w_complete ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill     <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (w_load_direct || w_load_held) begin
                r_fill <= '0;
            end else if (w_accept) begin
                r_fill <= w_frame;
            end
            if (w_store) begin
                r_hold_cnt <= w_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_out   <= '0;
            r_p_count <= '0;
            r_p_valid <= 1'b0;
        end else if (w_load_direct) begin
            r_p_out   <= w_frame;
            r_p_count <= w_cnt;
            r_p_valid <= 1'b1;
        end else if (w_load_held) begin
            r_p_out   <= r_fill;
            r_p_count <= r_hold_cnt;
            r_p_valid <= 1'b1;
        end else if (r_p_valid && bus.p_ready) begin
            r_p_valid <= 1'b0;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.p_out   = r_p_out;
    assign bus.p_count = r_p_count;
    assign bus.p_valid = r_p_valid;
endmodule

// File: doc/sipo_dbuf.md
SIPO_DBUF -- requirements
Module: sipo_dbuf

Interface
REQ-001 Parameter W, default 32, lane width in bits (DATA_WIDTH*2, one complex sample).
REQ-002 Parameter N, default 8, lanes per parallel frame (PE_NUM); N >= 2.
REQ-003 Parameter CW, default $clog2(N+1), width of p_count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_in  input  W  serial sample.
REQ-007 s_valid  input  1  s_in valid this cycle.
REQ-008 s_last  input  1  qualified by s_valid; current word closes the frame early.
REQ-009 s_ready  output  1  block accepts s_in this cycle.
REQ-010 p_out  output  N*W  parallel frame; lane i occupies bits [i*W+W-1 : i*W].
REQ-011 p_count  output  CW  number of valid lanes in p_out (1..N).
REQ-012 p_valid  output  1  p_out/p_count hold a frame.
REQ-013 p_ready  input  1  downstream consumes the frame this cycle.

Function
REQ-014 Accept = s_valid && s_ready at a rising edge; transfer out = p_valid && p_ready at a rising edge.
REQ-015 Internal state: fill buffer (N*W), write index idx (0..N-1), held flag, output register (p_out, p_count, p_valid).
REQ-016 First accepted word of a frame goes to lane 0, next to lane 1, and so on; idx increments per accept.
REQ-017 Frame completes on the accept where idx == N-1 or s_last == 1; completed frame count = idx+1; lanes >= count are zero.
REQ-018 Output free = !p_valid || p_ready, evaluated in the same cycle.
REQ-019 On the completing accept with output free, the frame including the current word loads directly into the output register; p_valid = 1 after that edge (1-cycle latency from final word); idx = 0; fill buffer cleared.
REQ-020 On the completing accept with output not free, the frame is stored in the fill buffer and held = 1; idx = 0.
REQ-021 s_ready = !held && !rst (combinational).
REQ-022 While held == 1, at the first edge with output free, fill buffer loads into the output register; held clears; s_ready is 1 in the following cycle.
REQ-023 Transfer out without a new frame loading on the same edge: p_valid = 0; p_out and p_count keep their values.
REQ-024 Transfer out and frame load on the same edge: the new frame replaces the old one; p_valid stays 1 (no bubble).
REQ-025 Non-accept cycles (s_valid = 0) leave idx and the fill buffer unchanged; partial frames wait indefinitely.
REQ-026 While p_valid = 1 and p_ready = 0, p_out and p_count are stable.
REQ-027 Sustained throughput: with p_ready tied high, one word per cycle indefinitely, one frame per N cycles.
REQ-028 s_last on the first word of a frame yields p_count = 1 with only lane 0 non-zero.

Reset
REQ-029 rst asserted: idx = 0, held = 0, fill buffer = 0, p_out = 0, p_count = 0, p_valid = 0, immediately and independent of clk.
REQ-030 Reset mid-frame or mid-hold discards all partial and pending data; the first accept after deassertion writes lane 0.
REQ-031 Inputs are ignored while rst is high; s_ready = 0 during reset.

Verification (N=8, W=32)
REQ-032 p_ready = 1; words 1..8 accepted on consecutive edges -> after the 8th edge p_valid = 1, lanes 0..7 = 1..8, p_count = 8; p_valid = 0 one cycle later.
REQ-033 p_ready = 0; stream 1..16 -> frame 1..8 in output, s_ready = 0 after the 16th word; raise p_ready for one cycle -> p_out = 9..16, s_ready = 1 the next cycle, p_valid stays 1.
REQ-034 Words 5, 6, 7 with s_last on 7 -> p_count = 3, lanes 0..2 = 5, 6, 7, lanes 3..7 = 0.
REQ-035 Assert rst after 4 accepted words (and separately while held = 1) -> all outputs 0 at once; after release, words 1..8 produce p_out lanes = 1..8.
REQ-036 p_ready = 1, 24 back-to-back words 1..24 with s_valid gaps inserted randomly -> three frames 1..8, 9..16, 17..24 in order, each with p_count = 8 and no lost or duplicated words.
REQ-037 s_last on the first word (value 0xAA) -> p_count = 1, lane 0 = 0xAA, all other lanes = 0.
